key_conditioner: RTL

Input-conditioning stage between the raw board push-buttons (`KEY`, active-low) and the `top` control logic. Per key it synchronizes the asynchronous input, debounces it with a saturating counter, and produces a clean level plus single-cycle press, release and auto-repeat strobes. Downstream FSMs in `top` consume these strobes instead of sampling `KEY` directly.

---
 rtl/key_conditioner_if.sv | 25 ++
 rtl/key_conditioner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw button inputs and conditioned key outputs.
// Latency: none, this is only a bundle of wires.
// Backpressure: none. The strobes are fire-and-forget pulses.
interface key_conditioner_if #(
  parameter int N_KEYS = 5
);
  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic [N_KEYS-1:0] key_strobe;

  // Board side: drives the buttons and consumes the conditioned outputs.
  modport master (
    output keys_raw,
    input  key_level, key_press, key_release, key_repeat, key_strobe
  );

  // Conditioner side.
  modport slave (
    input  keys_raw,
    output key_level, key_press, key_release, key_repeat, key_strobe
  );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, debouncer, and press/release/auto-repeat strobes.
// Latency: DEBOUNCE_CYCLES+2 cycles from a clean raw change to key_level and press/release.
// Backpressure: none. Strobes last one cycle, so consumers must sample every cycle.
module key_conditioner #(
  parameter int N_KEYS          = 5,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input logic              clk,
  input logic              reset_n,
  key_conditioner_if.slave kif
);
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RT_W   = (RT_MAX > 1) ? $clog2(RT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RT_W-1:0]  DELAY_LAST = RT_W'(REPEAT_DELAY - 1);
  localparam logic [RT_W-1:0]  RATE_LAST  = RT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  logic [N_KEYS-1:0] raw_pressed;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] level_w;
  logic [N_KEYS-1:0] press_w;
  logic [N_KEYS-1:0] release_w;
  logic [N_KEYS-1:0] repeat_w;

  // Normalise polarity up front so every later stage treats pressed as 1.
  assign raw_pressed = kif.keys_raw ^ {N_KEYS{ACTIVE_LOW}};

  // Two-flop synchronizer. Both flops reset to 0, the released state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_pressed;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic [RT_W-1:0]  rt_q;
    rep_state_e       state_q;
    logic             rise;
    logic             fall;

    // Debounce: accept a new value only after it has disagreed with stable for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q[i] != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = ~stable_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Edges are taken from the next state, so each strobe lands in the same cycle as the new level.
    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    // Debounce state plus registered press/release strobes.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stable_q  <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        cnt_q     <= cnt_d;
        press_q   <= rise;
        release_q <= fall;
      end
    end

    // Auto-repeat FSM. A release takes priority, so no repeat fires in the cycle the key lets go.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= IDLE;
        rt_q     <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= DELAY;
              rt_q    <= '0;
            end
          end
          DELAY: begin
            if (fall) begin
              state_q <= IDLE;
            end else if (rt_q == DELAY_LAST) begin
              repeat_q <= REPEAT_EN;
              rt_q     <= '0;
              state_q  <= REPEAT;
            end else begin
              rt_q <= rt_q + RT_W'(1);
            end
          end
          REPEAT: begin
            if (fall) begin
              state_q <= IDLE;
            end else if (rt_q == RATE_LAST) begin
              repeat_q <= REPEAT_EN;
              rt_q     <= '0;
            end else begin
              rt_q <= rt_q + RT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rt_q    <= '0;
          end
        endcase
      end
    end

    assign level_w[i]   = stable_q;
    assign press_w[i]   = press_q;
    assign release_w[i] = release_q;
    assign repeat_w[i]  = repeat_q;
  end

  assign kif.key_level   = level_w;
  assign kif.key_press   = press_w;
  assign kif.key_release = release_w;
  assign kif.key_repeat  = repeat_w;
  // Press and repeat are already registered, so this OR adds no extra cycle.
  assign kif.key_strobe  = press_w | repeat_w;

endmodule
